// File: rtl/serial_adder4_if.sv
//------------------------------------------------------------------------------
// Module   : serial_adder4_if
// Brief    : Request/result bundle for the bit-serial adder. The ovf signal
//            exists only when SERIAL_ADDER_OVF_EN is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface serial_adder4_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, s, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, s, cout, ovf
  );
`else
  modport master (
    output start, a, b, cin,
    input  busy, done, s, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, s, cout
  );
`endif
endinterface

`default_nettype wire

// File: rtl/serial_adder4.sv
//------------------------------------------------------------------------------
// Module   : serial_adder4
// Brief    : Bit-serial ripple-carry adder, one sum bit per clock LSB-first.
//            Optional signed-overflow output enabled by SERIAL_ADDER_OVF_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module serial_adder4 #(
  parameter int WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder4_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MSB_ONE  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic             carry;
  logic             carry_nxt;
  logic             sum_bit;
  logic             load;
  logic             last_bit;
  logic [WIDTH-1:0] s_q;
  logic             cout_q;

  // Single full-adder cell shared across all bit positions
  assign sum_bit   = a_sh[0] ^ b_sh[0] ^ carry;
  assign carry_nxt = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
  assign sum_nxt   = (sum_sh >> 1) | (sum_bit ? MSB_ONE : '0);
  assign last_bit  = (state == ADD) && (bit_cnt == LAST_BIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = ADD;
        end
      end
      ADD: begin
        if (last_bit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = ADD;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      carry   <= 1'b0;
      bit_cnt <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
    end else if (load) begin
      a_sh    <= bus.a;
      b_sh    <= bus.b;
      carry   <= bus.cin;
      bit_cnt <= '0;
    end else if (state == ADD) begin
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      sum_sh  <= sum_nxt;
      carry   <= carry_nxt;
      bit_cnt <= bit_cnt + CNT_W'(1);
      if (last_bit) begin
        s_q    <= sum_nxt;
        cout_q <= carry_nxt;
      end
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q;

  // On the MSB cycle, carry holds the carry into the MSB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (last_bit) begin
      ovf_q <= carry ^ carry_nxt;
    end
  end

  assign bus.ovf = ovf_q;
`endif

  assign bus.busy = (state == ADD);
  assign bus.done = (state == DONE);
  assign bus.s    = s_q;
  assign bus.cout = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder4.sv
//------------------------------------------------------------------------------
// Module   : tb_serial_adder4
// Brief    : Directed self-checking bench for serial_adder4 (W=4); checks ovf
//            when SERIAL_ADDER_OVF_EN is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_serial_adder4;

  localparam int W = 4;

  logic clk;
  logic rst;

  serial_adder4_if #(.WIDTH(W)) bus ();

  serial_adder4 #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
  } vec_t;

  int total;
  int bad;
  logic [W-1:0] prev_s;
  logic         prev_cout;
  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_busy"}, 32'(bus.busy), 32'd0);
    check({name, "_done"}, 32'(bus.done), 32'd0);
    check({name, "_s"},    32'(bus.s),    32'd0);
    check({name, "_cout"}, 32'(bus.cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check({name, "_ovf"},  32'(bus.ovf),  32'd0);
`endif
  endtask

  // One accepted start, exact latency check, result check, strobe width check
  task automatic do_op(input string name, input vec_t v);
    logic ok;
    @(negedge clk);
    bus.a     = v.a;
    bus.b     = v.b;
    bus.cin   = v.cin;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = ~v.a;
    bus.b     = ~v.b;
    bus.cin   = ~v.cin;
    ok = 1'b1;
    for (int i = 0; i < W; i++) begin
      if (!(bus.busy === 1'b1 && bus.done === 1'b0 &&
            bus.s === prev_s && bus.cout === prev_cout)) ok = 1'b0;
      @(posedge clk);
      #1;
    end
    check({name, "_busy_window"}, 32'(ok), 32'd1);
    check({name, "_done"}, 32'(bus.done), 32'd1);
    check({name, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    check({name, "_s"}, 32'(bus.s), 32'(v.s));
    check({name, "_cout"}, 32'(bus.cout), 32'(v.cout));
`ifdef SERIAL_ADDER_OVF_EN
    check({name, "_ovf"}, 32'(bus.ovf), 32'(v.ovf));
`endif
    prev_s    = v.s;
    prev_cout = v.cout;
    @(posedge clk);
    #1;
    check({name, "_done_one_cycle"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int ndone;
    int done_k;
    logic ok;
    logic [W-1:0] done_s;
    vec_t v;

    total     = 0;
    bad       = 0;
    prev_s    = '0;
    prev_cout = 1'b0;

    //          a      b      cin   s      cout  ovf
    vecs[0] = '{4'd7,  4'd5,  1'b0, 4'd12, 1'b0, 1'b1};
    vecs[1] = '{4'd15, 4'd1,  1'b0, 4'd0,  1'b1, 1'b0};
    vecs[2] = '{4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0};
    vecs[3] = '{4'd7,  4'd1,  1'b0, 4'd8,  1'b0, 1'b1};
    vecs[4] = '{4'd8,  4'd8,  1'b0, 4'd0,  1'b1, 1'b1};
    vecs[5] = '{4'd3,  4'd2,  1'b0, 4'd5,  1'b0, 1'b0};
    vecs[6] = '{4'd0,  4'd0,  1'b1, 4'd1,  1'b0, 1'b0};
    vecs[7] = '{4'd10, 4'd5,  1'b1, 4'd0,  1'b1, 1'b0};
    vecs[8] = '{4'd9,  4'd12, 1'b0, 4'd5,  1'b1, 1'b1};
    vecs[9] = '{4'd0,  4'd0,  1'b0, 4'd0,  1'b0, 1'b0};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i]);
    end

    // Start re-pulsed during ADD must be ignored
    @(negedge clk);
    bus.a = 4'd3; bus.b = 4'd4; bus.cin = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    ndone  = 0;
    done_k = -1;
    done_s = '0;
    for (int k = 0; k < 12; k++) begin
      if (bus.done === 1'b1) begin
        ndone++;
        done_k = k;
        done_s = bus.s;
      end
      if (k == 1) begin
        @(negedge clk);
        bus.a = 4'd9; bus.b = 4'd9; bus.start = 1'b1;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
    end
    check("ignored_start_ndone", 32'(ndone), 32'd1);
    check("ignored_start_latency", 32'(done_k), 32'(W));
    check("ignored_start_s", 32'(done_s), 32'd7);
    check("ignored_start_cout", 32'(bus.cout), 32'd0);
    prev_s = 4'd7; prev_cout = 1'b0;

    // Start held high: result every W+1 cycles, busy low only in DONE
    @(negedge clk);
    bus.a = 4'd2; bus.b = 4'd2; bus.cin = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    #1;
    ndone = 0;
    ok    = 1'b1;
    for (int k = 0; k < 3 * (W + 1); k++) begin
      if (bus.done !== ((k % (W + 1)) == W)) ok = 1'b0;
      if (bus.busy !== ~bus.done) ok = 1'b0;
      if (bus.done === 1'b1) begin
        ndone++;
        if (bus.s !== 4'd4 || bus.cout !== 1'b0) ok = 1'b0;
      end
      if (k < 3 * (W + 1) - 1) begin
        @(posedge clk);
        #1;
      end
    end
    bus.start = 1'b0;
    check("held_start_pattern", 32'(ok), 32'd1);
    check("held_start_ndone", 32'(ndone), 32'd3);
    @(posedge clk);
    #1;
    check("held_start_idle", 32'(bus.busy | bus.done), 32'd0);

    // Asynchronous reset in the middle of an operation
    @(negedge clk);
    bus.a = 4'd6; bus.b = 4'd6; bus.cin = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_outputs_zero("midop_reset");
    @(negedge clk);
    rst = 1'b0;
    ok = 1'b1;
    for (int k = 0; k < W + 3; k++) begin
      @(posedge clk);
      #1;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) ok = 1'b0;
    end
    check("midop_reset_no_done", 32'(ok), 32'd1);
    prev_s = '0; prev_cout = 1'b0;
    v = '{4'd1, 4'd1, 1'b0, 4'd2, 1'b0, 1'b0};
    do_op("after_reset", v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_adder4.md
# serial_adder4

Bit-serial ripple-carry adder, the addition counterpart to the team's combinational 4-bit ripple-borrow subtractor. Accepts two WIDTH-bit operands and a carry-in on a start pulse, computes one sum bit per clock LSB-first through a single full-adder cell and a carry flip-flop, then presents the registered sum and carry-out with a one-cycle done strobe. It serves as the ALU add path in lab datapaths where area matters more than latency.

## Interface
- WIDTH, 4, operand and sum width in bits; legal range 2 to 16.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when not busy.
- a  input  WIDTH  minuend-side operand (addend A), captured on accepted start.
- b  input  WIDTH  addend B, captured on accepted start.
- cin  input  1  carry-in, captured on accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle strobe: result valid.
- s  output  WIDTH  registered sum; holds last result.
- cout  output  1  registered carry-out; holds last result.
- ovf  output  1  signed overflow; present only with SERIAL_ADDER_OVF_EN.

## Operation
- States: IDLE, ADD, DONE. Reset state IDLE.
- IDLE or DONE with start=1: load a and b into shift registers, carry FF <= cin, bit counter <= 0, go to ADD.
- IDLE with start=0: stay. DONE with start=0: go to IDLE.
- ADD, each cycle: sum bit = a_sh[0] ^ b_sh[0] ^ c; next c = (a_sh[0] & b_sh[0]) | (c & (a_sh[0] ^ b_sh[0])); a_sh and b_sh shift right; sum bit enters MSB of internal sum shift register; counter increments.
- ADD with counter = WIDTH-1: after that bit, copy completed sum register to s, final carry to cout, go to DONE.
- start while in ADD is ignored; operands are not re-sampled.
- a, b, cin may change freely after the accepting edge.
- s and cout change only on ADD->DONE transition; they are stable at all other times.
- Arithmetic: {cout, s} = a + b + cin, unsigned, modulo 2^(WIDTH+1); no truncation.

## Timing
- Reset (async assert, any state): state IDLE, busy=0, done=0, s=0, cout=0, ovf=0, internal shift registers, carry FF and counter cleared. An operation in progress is abandoned; no done is produced.
- Reset release: first start is accepted on the first rising edge with rst low.
- Start accepted at edge E: busy=1 from E through edge E+WIDTH; done=1 and s/cout updated after edge E+WIDTH, for exactly one cycle.
- Latency: WIDTH+1 cycles start-to-done; throughput one result per WIDTH+1 cycles with back-to-back start held high.
- busy and done are never high simultaneously; both derived from registered state.
- start held high continuously: accepted in IDLE, re-accepted in DONE cycle.

## Configuration
- SERIAL_ADDER_OVF_EN defined: port ovf exists; on ADD->DONE, ovf <= carry into MSB ^ carry out of MSB (two's-complement overflow); holds like s; reset 0.
- Undefined: port ovf and its logic are absent; all other behaviour identical.

## Test plan
- Reset, then a=7, b=5, cin=0, start pulse -> busy 4 cycles, done on 5th cycle, s=12, cout=0.
- a=15, b=1, cin=0 -> s=0, cout=1; then a=15, b=15, cin=1 -> s=15, cout=1.
- Start pulse with a=3, b=4; pulse start again with a=9, b=9 during ADD -> ignored, result s=7, cout=0, single done.
- start held high with a=2, b=2 -> done every 5 cycles, s=4 each time, busy low only in DONE cycle.
- Assert rst for one cycle at bit 2 of a=6+6 -> all outputs 0, no done; next start 1+1 -> s=2.
- With SERIAL_ADDER_OVF_EN: 7+1 -> s=8, ovf=1, cout=0; 8+8 -> s=0, ovf=1, cout=1; 3+2 -> ovf=0.
